// File: rtl/scoreboard_stall_unit_pkg.sv
// Shared core constants for the register scoreboard: default sizes and the
// opcodes whose destination writes return with variable latency.
package scoreboard_stall_unit_pkg;

    localparam int SB_NUM_REGS    = 32;
    localparam int SB_REG_BITS    = 5;
    localparam int SB_MAX_PENDING = 4;
    localparam int SB_CNT_BITS    = 3;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    // Loads are the only opcode class that always writes back late.
    function automatic logic is_long_opcode(input opcode_e op);
        return op == OPC_LOAD;
    endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// One saturating pending-write counter for a single architectural register.
module scoreboard_entry #(
    parameter int CNT_BITS = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                inc,
    input  logic                dec,
    output logic [CNT_BITS-1:0] count,
    output logic                nonzero
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    // inc and dec together cancel; both directions saturate.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec && count != CNT_MAX) begin
            count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign nonzero = |count;

endmodule

// File: rtl/scoreboard_stall_unit.sv
// Register scoreboard: tracks outstanding long-latency writes per register
// and stalls decode on source hazards or when the pending pool is full.
module scoreboard_stall_unit
    import scoreboard_stall_unit_pkg::*;
#(
    parameter int NUM_REGS    = SB_NUM_REGS,
    parameter int REG_BITS    = SB_REG_BITS,
    parameter int MAX_PENDING = SB_MAX_PENDING,
    parameter int CNT_BITS    = SB_CNT_BITS,
    parameter int PEND_BITS   = $clog2(MAX_PENDING + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic                 issue_long,
    input  logic [REG_BITS-1:0]  issue_rd,
    input  logic [REG_BITS-1:0]  rs1,
    input  logic [REG_BITS-1:0]  rs2,
    input  logic                 rs1_read,
    input  logic                 rs2_read,
    input  logic                 complete_valid,
    input  logic [REG_BITS-1:0]  complete_rd,
    output logic                 stall_decode,
    output logic                 issue_accept,
    output logic                 rs1_pending,
    output logic                 rs2_pending,
    output logic [PEND_BITS-1:0] pending_total,
    output logic                 full,
    output logic                 underflow_error
);

    localparam logic [PEND_BITS-1:0] PEND_MAX = PEND_BITS'(MAX_PENDING);
    localparam logic [CNT_BITS-1:0]  CNT_ONE  = CNT_BITS'(1);

    logic [NUM_REGS-1:0][CNT_BITS-1:0] cnt;
    logic [NUM_REGS-1:0]               nz;
    logic                              issue_cnt;
    logic                              comp_ok;
    logic                              comp_bad;
    logic                              rs1_busy;
    logic                              rs2_busy;
    logic                              rs1_release;
    logic                              rs2_release;

    // x0 is hardwired as never pending.
    assign cnt[0] = '0;
    assign nz[0]  = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        scoreboard_entry #(
            .CNT_BITS (CNT_BITS)
        ) u_entry (
            .clock   (clock),
            .reset   (reset),
            .inc     (issue_cnt && issue_rd == REG_BITS'(i)),
            .dec     (comp_ok && complete_rd == REG_BITS'(i)),
            .count   (cnt[i]),
            .nonzero (nz[i])
        );
    end

    assign full = (pending_total == PEND_MAX);

    // A completion retiring the last pending write clears the hazard this cycle.
    assign rs1_busy    = rs1_read && nz[rs1];
    assign rs2_busy    = rs2_read && nz[rs2];
    assign rs1_release = complete_valid && complete_rd == rs1 && cnt[rs1] == CNT_ONE;
    assign rs2_release = complete_valid && complete_rd == rs2 && cnt[rs2] == CNT_ONE;
    assign rs1_pending = rs1_busy && !rs1_release;
    assign rs2_pending = rs2_busy && !rs2_release;

    assign stall_decode = issue_valid &&
                          (rs1_pending || rs2_pending || (issue_long && full && !complete_valid));
    assign issue_accept = issue_valid && !stall_decode;

    assign issue_cnt = issue_accept && issue_long && issue_rd != '0;
    assign comp_ok   = complete_valid && nz[complete_rd];
    assign comp_bad  = complete_valid && complete_rd != '0 && !nz[complete_rd];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_total <= '0;
        end else begin
            case ({issue_cnt, comp_ok})
                2'b10: if (pending_total != PEND_MAX) pending_total <= pending_total + 1'b1;
                2'b01: if (pending_total != '0) pending_total <= pending_total - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            underflow_error <= 1'b0;
        end else if (comp_bad) begin
            underflow_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_scoreboard_stall_unit.sv
// Directed bench for scoreboard_stall_unit: hazards, full pool, WAW, x0, underflow, reset.
module tb_scoreboard_stall_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       issue_valid, issue_long;
    logic [4:0] issue_rd, rs1, rs2, complete_rd;
    logic       rs1_read, rs2_read, complete_valid;
    logic       stall_decode, issue_accept, rs1_pending, rs2_pending, full, underflow_error;
    logic [2:0] pending_total;

    int n_checks = 0;
    int n_bad    = 0;

    scoreboard_stall_unit dut (
        .clock           (clock),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_long      (issue_long),
        .issue_rd        (issue_rd),
        .rs1             (rs1),
        .rs2             (rs2),
        .rs1_read        (rs1_read),
        .rs2_read        (rs2_read),
        .complete_valid  (complete_valid),
        .complete_rd     (complete_rd),
        .stall_decode    (stall_decode),
        .issue_accept    (issue_accept),
        .rs1_pending     (rs1_pending),
        .rs2_pending     (rs2_pending),
        .pending_total   (pending_total),
        .full            (full),
        .underflow_error (underflow_error)
    );

    always #5 clock = ~clock;

    task automatic idle();
        issue_valid = 0; issue_long = 0; issue_rd = 0;
        rs1 = 0; rs2 = 0; rs1_read = 0; rs2_read = 0;
        complete_valid = 0; complete_rd = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_long_to(input logic [4:0] rd);
        idle();
        issue_valid = 1; issue_long = 1; issue_rd = rd;
        tick();
    endtask

    task automatic complete_to(input logic [4:0] rd);
        idle();
        complete_valid = 1; complete_rd = rd;
        tick();
    endtask

    task automatic test_reset();
        idle();
        #2 reset = 1;
        #1;
        n_checks++; if (pending_total !== 3'd0) begin n_bad++; $display("FAIL reset_total got=%0d want=0", pending_total); end
        n_checks++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%0b want=0", full); end
        n_checks++; if (underflow_error !== 1'b0) begin n_bad++; $display("FAIL reset_uf got=%0b want=0", underflow_error); end
        issue_valid = 1; issue_long = 1; issue_rd = 3; rs1 = 3; rs1_read = 1;
        #1;
        n_checks++; if (stall_decode !== 1'b0 || issue_accept !== 1'b1) begin n_bad++; $display("FAIL reset_stall got=%0b/%0b want=0/1", stall_decode, issue_accept); end
        tick();
        n_checks++; if (pending_total !== 3'd0) begin n_bad++; $display("FAIL reset_hold_total got=%0d want=0", pending_total); end
        reset = 0;
        idle();
        #1;
    endtask

    task automatic test_load_use();
        idle();
        issue_valid = 1; issue_long = 1; issue_rd = 5;
        #1;
        n_checks++; if (issue_accept !== 1'b1) begin n_bad++; $display("FAIL lu_accept got=%0b want=1", issue_accept); end
        tick();
        idle();
        issue_valid = 1; issue_rd = 6; rs1 = 5; rs1_read = 1;
        #1;
        n_checks++; if (rs1_pending !== 1'b1 || stall_decode !== 1'b1 || issue_accept !== 1'b0) begin n_bad++;
            $display("FAIL lu_stall got=%0b/%0b/%0b want=1/1/0", rs1_pending, stall_decode, issue_accept); end
        n_checks++; if (pending_total !== 3'd1) begin n_bad++; $display("FAIL lu_total got=%0d want=1", pending_total); end
        complete_valid = 1; complete_rd = 5;
        #1;
        n_checks++; if (rs1_pending !== 1'b0 || stall_decode !== 1'b0 || issue_accept !== 1'b1) begin n_bad++;
            $display("FAIL lu_release got=%0b/%0b/%0b want=0/0/1", rs1_pending, stall_decode, issue_accept); end
        tick();
        idle();
        rs1 = 5; rs1_read = 1;
        #1;
        n_checks++; if (rs1_pending !== 1'b0 || pending_total !== 3'd0) begin n_bad++;
            $display("FAIL lu_after got=%0b/%0d want=0/0", rs1_pending, pending_total); end
    endtask

    task automatic test_full();
        for (int r = 1; r <= 4; r++) issue_long_to(5'(r));
        idle();
        #1;
        n_checks++; if (full !== 1'b1 || pending_total !== 3'd4) begin n_bad++;
            $display("FAIL full_set got=%0b/%0d want=1/4", full, pending_total); end
        issue_valid = 1; issue_long = 1; issue_rd = 8;
        #1;
        n_checks++; if (stall_decode !== 1'b1 || issue_accept !== 1'b0) begin n_bad++;
            $display("FAIL full_stall got=%0b/%0b want=1/0", stall_decode, issue_accept); end
        complete_valid = 1; complete_rd = 1;
        #1;
        n_checks++; if (stall_decode !== 1'b0 || issue_accept !== 1'b1) begin n_bad++;
            $display("FAIL full_swap got=%0b/%0b want=0/1", stall_decode, issue_accept); end
        tick();
        idle();
        rs1 = 8; rs1_read = 1; rs2 = 1; rs2_read = 1;
        #1;
        n_checks++; if (pending_total !== 3'd4 || full !== 1'b1) begin n_bad++;
            $display("FAIL full_after got=%0d/%0b want=4/1", pending_total, full); end
        n_checks++; if (rs1_pending !== 1'b1 || rs2_pending !== 1'b0) begin n_bad++;
            $display("FAIL full_regs got=%0b/%0b want=1/0", rs1_pending, rs2_pending); end
        complete_to(2); complete_to(3); complete_to(4); complete_to(8);
        idle();
        #1;
        n_checks++; if (pending_total !== 3'd0 || full !== 1'b0) begin n_bad++;
            $display("FAIL full_drain got=%0d/%0b want=0/0", pending_total, full); end
    endtask

    task automatic test_waw();
        issue_long_to(7);
        issue_long_to(7);
        idle();
        rs2 = 7; rs2_read = 1;
        #1;
        n_checks++; if (rs2_pending !== 1'b1 || pending_total !== 3'd2) begin n_bad++;
            $display("FAIL waw_two got=%0b/%0d want=1/2", rs2_pending, pending_total); end
        complete_valid = 1; complete_rd = 7;
        #1;
        n_checks++; if (rs2_pending !== 1'b1) begin n_bad++; $display("FAIL waw_first_cmp got=%0b want=1", rs2_pending); end
        tick();
        complete_valid = 0;
        #1;
        n_checks++; if (rs2_pending !== 1'b1 || pending_total !== 3'd1) begin n_bad++;
            $display("FAIL waw_one got=%0b/%0d want=1/1", rs2_pending, pending_total); end
        complete_valid = 1;
        #1;
        n_checks++; if (rs2_pending !== 1'b0) begin n_bad++; $display("FAIL waw_release got=%0b want=0", rs2_pending); end
        tick();
        complete_valid = 0;
        #1;
        n_checks++; if (rs2_pending !== 1'b0 || pending_total !== 3'd0) begin n_bad++;
            $display("FAIL waw_clear got=%0b/%0d want=0/0", rs2_pending, pending_total); end
    endtask

    task automatic test_same_rd_swap();
        issue_long_to(10);
        idle();
        issue_valid = 1; issue_long = 1; issue_rd = 10;
        complete_valid = 1; complete_rd = 10;
        tick();
        idle();
        rs1 = 10; rs1_read = 1;
        #1;
        n_checks++; if (pending_total !== 3'd1 || rs1_pending !== 1'b1) begin n_bad++;
            $display("FAIL swap_same got=%0d/%0b want=1/1", pending_total, rs1_pending); end
        complete_to(10);
        idle();
        rs1 = 10; rs1_read = 1;
        #1;
        n_checks++; if (pending_total !== 3'd0 || rs1_pending !== 1'b0) begin n_bad++;
            $display("FAIL swap_drain got=%0d/%0b want=0/0", pending_total, rs1_pending); end
    endtask

    task automatic test_reg_zero();
        idle();
        issue_valid = 1; issue_long = 1; issue_rd = 0; rs1 = 0; rs1_read = 1;
        #1;
        n_checks++; if (rs1_pending !== 1'b0 || issue_accept !== 1'b1) begin n_bad++;
            $display("FAIL x0_issue got=%0b/%0b want=0/1", rs1_pending, issue_accept); end
        tick();
        n_checks++; if (pending_total !== 3'd0 || rs1_pending !== 1'b0) begin n_bad++;
            $display("FAIL x0_count got=%0d/%0b want=0/0", pending_total, rs1_pending); end
        complete_to(0);
        n_checks++; if (underflow_error !== 1'b0) begin n_bad++; $display("FAIL x0_complete got=%0b want=0", underflow_error); end
    endtask

    task automatic test_underflow();
        idle();
        #1;
        n_checks++; if (underflow_error !== 1'b0) begin n_bad++; $display("FAIL uf_pre got=%0b want=0", underflow_error); end
        complete_to(9);
        idle();
        rs1 = 9; rs1_read = 1;
        #1;
        n_checks++; if (underflow_error !== 1'b1 || pending_total !== 3'd0 || rs1_pending !== 1'b0) begin n_bad++;
            $display("FAIL uf_set got=%0b/%0d/%0b want=1/0/0", underflow_error, pending_total, rs1_pending); end
        tick(); tick(); tick();
        n_checks++; if (underflow_error !== 1'b1) begin n_bad++; $display("FAIL uf_sticky got=%0b want=1", underflow_error); end
    endtask

    task automatic test_reset_mid();
        issue_long_to(1); issue_long_to(2); issue_long_to(3);
        idle();
        #1;
        n_checks++; if (pending_total !== 3'd3) begin n_bad++; $display("FAIL rm_pre got=%0d want=3", pending_total); end
        #2 reset = 1;
        rs1 = 1; rs1_read = 1; issue_valid = 1;
        #1;
        n_checks++; if (pending_total !== 3'd0 || full !== 1'b0 || rs1_pending !== 1'b0) begin n_bad++;
            $display("FAIL rm_clear got=%0d/%0b/%0b want=0/0/0", pending_total, full, rs1_pending); end
        n_checks++; if (underflow_error !== 1'b0 || stall_decode !== 1'b0) begin n_bad++;
            $display("FAIL rm_flags got=%0b/%0b want=0/0", underflow_error, stall_decode); end
        tick();
        reset = 0;
        complete_to(1);
        idle();
        #1;
        n_checks++; if (underflow_error !== 1'b1 || pending_total !== 3'd0) begin n_bad++;
            $display("FAIL rm_stale got=%0b/%0d want=1/0", underflow_error, pending_total); end
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_full();
        test_waw();
        test_same_rd_swap();
        test_reg_zero();
        test_underflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
